// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan driver:
// display codes, segment bit masks and the code-to-glyph table.
package seg_pkg;

  typedef enum logic [3:0] {
    C_0     = 4'h0,
    C_1     = 4'h1,
    C_2     = 4'h2,
    C_3     = 4'h3,
    C_4     = 4'h4,
    C_5     = 4'h5,
    C_6     = 4'h6,
    C_7     = 4'h7,
    C_8     = 4'h8,
    C_9     = 4'h9,
    C_E     = 4'hA,
    C_H     = 4'hB,
    C_L     = 4'hC,
    C_F     = 4'hD,
    C_DASH  = 4'hE,
    C_BLANK = 4'hF
  } code_e;

  localparam logic [7:0] SEG_A  = 8'h01;
  localparam logic [7:0] SEG_B  = 8'h02;
  localparam logic [7:0] SEG_C  = 8'h04;
  localparam logic [7:0] SEG_D  = 8'h08;
  localparam logic [7:0] SEG_E  = 8'h10;
  localparam logic [7:0] SEG_F  = 8'h20;
  localparam logic [7:0] SEG_G  = 8'h40;
  localparam logic [7:0] SEG_DP = 8'h80;

  // Active-high {G,F,E,D,C,B,A}; entry 0 in the low bits.
  localparam logic [15:0][6:0] GLYPH_TAB = {
    7'h00, 7'h40, 7'h71, 7'h38,
    7'h76, 7'h79, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66,
    7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/seg_scan_driver_if.sv
// Host-side bundle of the scan driver: message load
// inputs and the multiplexed display outputs.
interface seg_scan_driver_if #(
  parameter int DIGITS = 4
) ();
  logic [4*DIGITS-1:0] msg;
  logic [DIGITS-1:0]   dp_mask;
  logic                noti;
  logic                blink_en;
  logic [7:0]          seg;
  logic [DIGITS-1:0]   dig_sel;
  logic                frame_done;

  modport master (
    output msg, dp_mask, noti, blink_en,
    input  seg, dig_sel, frame_done
  );

  modport slave (
    input  msg, dp_mask, noti, blink_en,
    output seg, dig_sel, frame_done
  );
endinterface

// File: rtl/seg_glyph.sv
// Combinational code-to-segment lookup, active-high,
// with digit blanking and decimal point.
module seg_glyph
  import seg_pkg::*;
(
  input  logic [3:0] code,
  input  logic       blank,
  input  logic       dp,
  output logic [7:0] seg
);

  always_comb begin
    seg = '0;
    if (!blank) seg[6:0] = GLYPH_TAB[code];
    if (dp) seg = seg | SEG_DP;
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment scan driver with shadowed message,
// leading-zero blanking and whole-display blink.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int CLK_DIV    = 1000,
  parameter int BLINK_DIV  = 256,
  parameter int ACTIVE_LOW = 1,
  parameter int LZB        = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [4*DIGITS-1:0] msg,
  input  logic [DIGITS-1:0]   dp_mask,
  input  logic                noti,
  input  logic                blink_en,
  output logic [7:0]          seg,
  output logic [DIGITS-1:0]   dig_sel,
  output logic                frame_done
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int IW = $clog2(DIGITS);
  localparam int BW = $clog2(2*BLINK_DIV);

  localparam logic [CW-1:0] CNT_MAX  = CW'(CLK_DIV-1);
  localparam logic [IW-1:0] IDX_MAX  = IW'(DIGITS-1);
  localparam logic [BW-1:0] BLK_MAX  = BW'(2*BLINK_DIV-1);
  localparam logic [BW-1:0] BLK_HALF = BW'(BLINK_DIV);

  localparam logic [7:0] SEG_OFF =
    (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] DIG_OFF =
    (ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [2:0]          sync_q, sync_d;
  logic [4*DIGITS-1:0] msg_q, msg_d;
  logic [DIGITS-1:0]   dp_q, dp_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic                vld_q, vld_d;
  logic [BW-1:0]       blk_q, blk_d;
  logic                off_q, off_d;
  logic [7:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   dig_q, dig_d;
  logic                frame_q, frame_d;

  logic              load, adv, wrap;
  logic              upd, blank_d;
  logic [DIGITS:0]   lz;
  logic [3:0]        cur_code;
  logic              cur_dp, cur_blank;
  logic [DIGITS-1:0] oh;
  logic [7:0]        glyph;

  always_comb begin
    sync_d = {sync_q[1:0], noti};
    load   = sync_q[1] & ~sync_q[2];
    msg_d  = load ? msg : msg_q;
    dp_d   = load ? dp_mask : dp_q;

    adv   = (cnt_q == CNT_MAX);
    cnt_d = adv ? '0 : cnt_q + 1'b1;
    wrap  = adv && vld_q && (idx_q == IDX_MAX);
    vld_d = vld_q | adv;

    // First advance after reset selects digit 0 itself.
    idx_d = idx_q;
    if (wrap) idx_d = '0;
    else if (adv && vld_q) idx_d = idx_q + 1'b1;
    frame_d = wrap;

    blk_d = blk_q;
    if (!blink_en) blk_d = '0;
    else if (wrap)
      blk_d = (blk_q == BLK_MAX) ? '0 : blk_q + 1'b1;
    blank_d = blink_en && (blk_d >= BLK_HALF);

    upd   = adv | (off_q & ~blink_en);
    off_d = upd ? blank_d : off_q;
  end

  always_comb begin
    lz[DIGITS] = 1'b1;
    for (int i = DIGITS-1; i >= 0; i--)
      lz[i] = lz[i+1] && (msg_q[4*i +: 4] == C_0);
    cur_code  = C_BLANK;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    oh        = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_d == IW'(i)) begin
        cur_code  = msg_q[4*i +: 4];
        cur_dp    = dp_q[i];
        cur_blank = (LZB != 0) && (i != 0) && lz[i];
        oh[i]     = 1'b1;
      end
    end
  end

  seg_glyph u_glyph (
    .code  (cur_code),
    .blank (cur_blank),
    .dp    (cur_dp),
    .seg   (glyph)
  );

  always_comb begin
    seg_d = seg_q;
    dig_d = dig_q;
    if (upd) begin
      seg_d = blank_d ? SEG_OFF : glyph ^ SEG_OFF;
      dig_d = blank_d ? DIG_OFF : oh ^ DIG_OFF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      msg_q   <= {DIGITS{C_BLANK}};
      dp_q    <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      vld_q   <= 1'b0;
      blk_q   <= '0;
      off_q   <= 1'b0;
      seg_q   <= SEG_OFF;
      dig_q   <= DIG_OFF;
      frame_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      msg_q   <= msg_d;
      dp_q    <= dp_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
      blk_q   <= blk_d;
      off_q   <= off_d;
      seg_q   <= seg_d;
      dig_q   <= dig_d;
      frame_q <= frame_d;
    end
  end

  assign seg        = seg_q;
  assign dig_sel    = dig_q;
  assign frame_done = frame_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: 4 digits, 4-cycle
// digit slot, 2-frame blink, active-low outputs.
module tb_seg_scan_driver;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk  = 0;
  int   n_pass = 0;

  seg_scan_driver_if #(.DIGITS(4)) bus ();

  seg_scan_driver #(
    .DIGITS     (4),
    .CLK_DIV    (4),
    .BLINK_DIV  (2),
    .ACTIVE_LOW (1),
    .LZB        (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .msg        (bus.msg),
    .dp_mask    (bus.dp_mask),
    .noti       (bus.noti),
    .blink_en   (bus.blink_en),
    .seg        (bus.seg),
    .dig_sel    (bus.dig_sel),
    .frame_done (bus.frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [15:0] got,
                       input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  task automatic load(input logic [15:0] m,
                      input logic [3:0] dp);
    bus.msg     = m;
    bus.dp_mask = dp;
    bus.noti    = 1'b1;
    repeat (4) @(negedge clk);
    bus.noti    = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic show(input string tag, input int d,
                      input logic [7:0] exp);
    logic [3:0] want;
    int n;
    want = ~(4'b0001 << d);
    n = 0;
    while (bus.dig_sel == want && n < 40) begin
      @(negedge clk);
      n++;
    end
    while (bus.dig_sel != want && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_sel"}, 16'(bus.dig_sel), 16'(want));
    check(tag, 16'(bus.seg), 16'(exp));
  endtask

  initial begin
    int n;
    int on_cnt;
    int off_cnt;
    logic [7:0] exp0 [4];
    rst_n        = 1'b0;
    bus.msg      = '0;
    bus.dp_mask  = '0;
    bus.noti     = 1'b0;
    bus.blink_en = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_seg", 16'(bus.seg), 16'hFF);
    check("rst_dig", 16'(bus.dig_sel), 16'hF);
    check("rst_fd", 16'(bus.frame_done), 16'h0);

    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("pre_scan_dig", 16'(bus.dig_sel), 16'hF);
    @(negedge clk);
    check("first_dig", 16'(bus.dig_sel), 16'hE);
    check("first_seg", 16'(bus.seg), 16'hFF);

    load(16'h0012, 4'b0000);
    exp0 = '{8'hA4, 8'hF9, 8'hFF, 8'hFF};
    for (int i = 0; i < 4; i++)
      show($sformatf("m0012_d%0d", i), i, exp0[i]);

    load(16'h0000, 4'b0000);
    exp0 = '{8'hC0, 8'hFF, 8'hFF, 8'hFF};
    for (int i = 0; i < 4; i++)
      show($sformatf("m0000_d%0d", i), i, exp0[i]);

    load(16'hE1F7, 4'b0001);
    exp0 = '{8'h78, 8'hFF, 8'hF9, 8'hBF};
    for (int i = 0; i < 4; i++)
      show($sformatf("mE1F7_d%0d", i), i, exp0[i]);

    bus.msg     = 16'h8888;
    bus.dp_mask = 4'b1111;
    repeat (20) @(negedge clk);
    show("nonoti_d0", 0, 8'h78);
    show("nonoti_d3", 3, 8'hBF);

    n = 0;
    while (!bus.frame_done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("fd_seen", 16'(bus.frame_done), 16'h1);
    @(negedge clk);
    check("fd_width", 16'(bus.frame_done), 16'h0);
    n = 1;
    while (!bus.frame_done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("fd_period", 16'(n), 16'd16);

    bus.blink_en = 1'b1;
    on_cnt  = 0;
    off_cnt = 0;
    for (int k = 0; k <= 64; k++) begin
      if (k > 0) @(negedge clk);
      if (k < 32 && bus.dig_sel != 4'hF) on_cnt++;
      if (k >= 32 && k < 64 && bus.dig_sel == 4'hF
          && bus.seg == 8'hFF) off_cnt++;
      if (k == 64)
        check("blink_resume", 16'(bus.dig_sel), 16'hE);
    end
    check("blink_on", 16'(on_cnt), 16'd32);
    check("blink_off", 16'(off_cnt), 16'd32);

    repeat (40) @(negedge clk);
    check("blink_off2_dig", 16'(bus.dig_sel), 16'hF);
    check("blink_off2_seg", 16'(bus.seg), 16'hFF);
    bus.blink_en = 1'b0;
    @(negedge clk);
    check("unblink_dig", 16'(bus.dig_sel), 16'hB);
    check("unblink_seg", 16'(bus.seg), 16'hF9);

    bus.blink_en = 1'b1;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_seg", 16'(bus.seg), 16'hFF);
    check("arst_dig", 16'(bus.dig_sel), 16'hF);
    check("arst_fd", 16'(bus.frame_done), 16'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rerst_pre_dig", 16'(bus.dig_sel), 16'hF);
    @(negedge clk);
    check("rerst_d0_dig", 16'(bus.dig_sel), 16'hE);
    check("rerst_d0_seg", 16'(bus.seg), 16'hFF);
    repeat (4) @(negedge clk);
    check("rerst_d1_dig", 16'(bus.dig_sel), 16'hD);
    check("rerst_d1_seg", 16'(bus.seg), 16'hFF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter DIGITS, default 4, giving the number of multiplexed 7-segment digits (range 2..8).
REQ-002 SHALL have parameter CLK_DIV, default 1000, giving the clk cycles each digit is driven (at least 2).
REQ-003 SHALL have parameter BLINK_DIV, default 256, giving the scan frames per blink half-period (at least 1).
REQ-004 SHALL have parameter ACTIVE_LOW, default 1; when 1, seg and dig_sel are active-low, and when 0 they are active-high.
REQ-005 SHALL have parameter LZB, default 1, enabling leading-zero blanking.
REQ-006 SHALL have port clk, input, 1 bit, the single clock; all logic runs on its rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit, reset; it is asynchronous and active-low.
REQ-008 SHALL have port msg, input, 4*DIGITS bits: one display code per digit, digit 0 = msg[3:0] (rightmost).
REQ-009 SHALL have port dp_mask, input, DIGITS bits: bit i lights the DP of digit i.
REQ-010 SHALL have port noti, input, 1 bit: an asynchronous load request; its rising edge loads msg and dp_mask.
REQ-011 SHALL have port blink_en, input, 1 bit: the whole display blinks while it is high.
REQ-012 SHALL have port seg, output, 8 bits, segments {DP,G,F,E,D,C,B,A} from MSB to LSB.
REQ-013 SHALL have port dig_sel, output, DIGITS bits: a one-hot digit enable; bit i drives digit i.
REQ-014 SHALL have port frame_done, output, 1 bit: a one-cycle pulse at the end of each full scan.

Function
REQ-015 SHALL pass noti through a 2-flop synchroniser and detect its rising edge; msg and dp_mask are captured into a shadow register on the 3rd rising clk edge after noti rises, and the host holds them stable over that window.
REQ-016 SHALL display only from the shadow register; msg and dp_mask changes without a noti edge have no effect.
REQ-017 SHALL map codes 0-9 to decimal glyphs, 0xA to 'E', 0xB to 'H', 0xC to 'L', 0xD to 'F', 0xE to '-' (G only), and 0xF to blank.
REQ-018 SHALL, when LZB=1, blank digit i (i>0) whose code is 0 and all of whose higher digits are 0; digit 0 is never zero-blanked, so an all-zero message shows "0".
REQ-019 SHALL use a prescaler that counts 0..CLK_DIV-1; on wrap, the digit index advances by 1, and it wraps from DIGITS-1 to 0.
REQ-020 SHALL register seg and dig_sel, updating them on the same edge the index changes, and both SHALL reflect the new index and the current shadow.
REQ-021 SHALL drive exactly one dig_sel bit active at any time, except in reset or during a blink-off phase.
REQ-022 SHALL pulse frame_done high for exactly 1 cycle on the edge where the index wraps from DIGITS-1 to 0.
REQ-023 SHALL, while blink_en=1, count frames in a blink counter; for BLINK_DIV frames the display is shown, and for the next BLINK_DIV frames seg and dig_sel are all inactive; the cycle then repeats.
REQ-024 SHALL clear the blink counter to 0 while blink_en=0, so blinking always starts with the display shown.
REQ-025 SHALL, if a noti load and a digit advance occur on the same edge, drive the advanced digit from the old shadow, with the new shadow used from the next advance; a digit is never half-updated.
REQ-026 SHALL, when ACTIVE_LOW=1, invert every glyph and enable bit, so that lit = 0.

Reset
REQ-027 SHALL, while rst_n is low, immediately force: seg all off, dig_sel all off, frame_done=0, prescaler=0, index=0, blink counter=0, synchroniser flops=0, shadow codes all 0xF and dp all 0.
REQ-028 SHALL, after rst_n deasserts, show digit 0 (blank) after the first CLK_DIV cycles; a reset asserted mid-scan or mid-blink aborts the scan or blink with no residual state.

Structure
REQ-029 SHALL take its code constants (0x0-0xF), segment bit masks and the glyph table from a shared package seg_pkg.
REQ-030 SHALL implement the code-to-glyph lookup (active-high) in a combinational sub-module seg_glyph, instantiated once on the selected digit.

Verification (DIGITS=4, CLK_DIV=4, BLINK_DIV=2, ACTIVE_LOW=1, LZB=1)
REQ-031 SHALL cover: reset asserted -> seg=8'hFF, dig_sel=4'hF, frame_done=0; after release, scan starts at dig_sel=4'b1110.
REQ-032 SHALL cover: msg=16'h0012 with a noti pulse -> digit0 seg=8'hA4, digit1 seg=8'hF9, digits 2 and 3 seg=8'hFF.
REQ-033 SHALL cover: msg=16'h0000 with a noti pulse -> digit0 seg=8'hC0, other digits 8'hFF; msg=16'hE1F7 with dp_mask=4'b0001 -> digit0 seg=8'h78, digit2 seg=8'hF9, digit3 seg=8'hBF.
REQ-034 SHALL cover: msg changed without noti -> display unchanged; frame_done pulses every 16 cycles, 1 cycle wide.
REQ-035 SHALL cover: blink_en=1 -> 2 frames displayed, then 32 cycles with seg=8'hFF and dig_sel=4'hF, then repeat; blink_en=0 -> immediate normal scan.
REQ-036 SHALL cover: rst_n pulsed low mid-frame while blinking -> outputs go off asynchronously, shadow reads blank, and the scan restarts at digit 0.
